// File: rtl/eth_mac_pkg.sv
// rtl/eth_mac_pkg.sv - shared types and constants for the PHY receive emulator
package eth_mac_pkg;

  typedef enum logic [1:0] {
    SPEED_1G   = 2'b00,
    SPEED_100M = 2'b01,
    SPEED_10M  = 2'b11
  } link_speed_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  // Index of the SFD within the 8-byte preamble sequence.
  localparam logic [15:0] SFD_INDEX    = 16'd7;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    IFG,
    DROP
  } phy_rx_emu_state_t;

  // First symbol of a byte: the whole byte at 1G, the low nibble in nibble modes.
  function automatic logic [7:0] first_symbol(input logic [7:0] b, input logic nibble_mode);
    return nibble_mode ? {4'h0, b[3:0]} : b;
  endfunction

endpackage

// File: rtl/eth_slot_timer.sv
// rtl/eth_slot_timer.sv - symbol slot divider and nibble-phase toggle
module eth_slot_timer
  import eth_mac_pkg::*;
#(
  parameter int CLKS_PER_NIB_100 = 5,
  parameter int CLKS_PER_NIB_10  = 50
) (
  input  logic       clk_125,
  input  logic       reset,
  input  logic       restart,
  input  logic [1:0] speed_q,
  output logic       stb,
  output logic       nib_phase
);

  logic [15:0] cnt;
  logic [15:0] reload;

  // Slot length minus one for the selected speed; 1G (and 2'b10) slots are one cycle.
  always_comb begin
    reload = '0;
    if (speed_q == SPEED_100M) begin
      reload = 16'(CLKS_PER_NIB_100 - 1);
    end else if (speed_q == SPEED_10M) begin
      reload = 16'(CLKS_PER_NIB_10 - 1);
    end
  end

  assign stb = (cnt == '0);

  // Count down to the slot boundary; restart aligns the first slot to the frame start.
  // nib_phase is 1 while the high nibble is on the wire, so the next boundary starts a byte.
  always_ff @(posedge clk_125) begin
    if (reset || restart) begin
      cnt       <= reload;
      nib_phase <= 1'b0;
    end else if (stb) begin
      cnt       <= reload;
      nib_phase <= speed_q[0] & ~nib_phase;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

endmodule

// File: rtl/eth_phy_rx_emu.sv
// rtl/eth_phy_rx_emu.sv - AXI-Stream to GMII/MII receive symbol emulator
module eth_phy_rx_emu
  import eth_mac_pkg::*;
#(
  parameter int       IFG_BYTES        = 12,
  parameter bit       PREAMBLE_EN      = 1'b1,
  parameter int       CLKS_PER_NIB_100 = 5,
  parameter int       CLKS_PER_NIB_10  = 50,
  parameter int       CNT_WIDTH        = 16
) (
  input  logic                 clk_125,
  input  logic                 reset,
  input  logic [1:0]           link_speed,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic                 s_axis_tready,
  output logic [7:0]           phy_rxd,
  output logic                 phy_rx_dv,
  output logic                 phy_rx_er,
  output logic                 phy_rx_stb,
  output logic [CNT_WIDTH-1:0] frames_sent,
  output logic [CNT_WIDTH-1:0] underruns
);

  phy_rx_emu_state_t state;
  logic [1:0]  speed_q;
  logic [7:0]  cur_byte;
  logic [15:0] byte_cnt;
  logic        seen_last;
  logic        und_pend;
  logic        tick;
  logic        nib_phase;
  logic        nib_mode;
  logic        launch;
  logic        accept;
  logic [1:0]  timer_speed;

  // While idle the timer follows the live speed so it is already aligned when speed_q latches.
  assign timer_speed = (state == IDLE) ? link_speed : speed_q;
  assign nib_mode    = speed_q[0];
  assign launch      = tick & (~nib_mode | nib_phase);
  assign accept      = ((state == DATA) & launch & s_axis_tvalid & ~seen_last & ~und_pend)
                     | ((state == IDLE) & s_axis_tvalid & ~PREAMBLE_EN);
  assign s_axis_tready = accept | (state == DROP);

  eth_slot_timer #(
    .CLKS_PER_NIB_100 (CLKS_PER_NIB_100),
    .CLKS_PER_NIB_10  (CLKS_PER_NIB_10)
  ) u_slot_timer (
    .clk_125   (clk_125),
    .reset     (reset),
    .restart   (state == IDLE),
    .speed_q   (timer_speed),
    .stb       (tick),
    .nib_phase (nib_phase)
  );

  // Frame sequencer: every PHY output is registered and only changes on a slot strobe.
  always_ff @(posedge clk_125) begin
    if (reset) begin
      state       <= IDLE;
      speed_q     <= 2'b00;
      cur_byte    <= '0;
      byte_cnt    <= '0;
      seen_last   <= 1'b0;
      und_pend    <= 1'b0;
      phy_rxd     <= '0;
      phy_rx_dv   <= 1'b0;
      phy_rx_er   <= 1'b0;
      phy_rx_stb  <= 1'b0;
      frames_sent <= '0;
      underruns   <= '0;
    end else begin
      phy_rx_stb <= 1'b0;
      case (state)
        IDLE: begin
          seen_last <= 1'b0;
          und_pend  <= 1'b0;
          if (s_axis_tvalid) begin
            speed_q    <= link_speed;
            phy_rx_stb <= 1'b1;
            phy_rx_dv  <= 1'b1;
            if (PREAMBLE_EN) begin
              cur_byte  <= PREAMBLE_BYTE;
              phy_rxd   <= first_symbol(PREAMBLE_BYTE, link_speed[0]);
              phy_rx_er <= 1'b0;
              byte_cnt  <= 16'd1;
              state     <= PREAMBLE;
            end else begin
              cur_byte  <= s_axis_tdata;
              phy_rxd   <= first_symbol(s_axis_tdata, link_speed[0]);
              phy_rx_er <= s_axis_tuser;
              seen_last <= s_axis_tlast;
              state     <= DATA;
            end
          end
        end
        PREAMBLE: if (tick) begin
          phy_rx_stb <= 1'b1;
          if (!launch) begin
            phy_rxd <= {4'h0, cur_byte[7:4]};
          end else if (byte_cnt == SFD_INDEX) begin
            cur_byte <= SFD_BYTE;
            phy_rxd  <= first_symbol(SFD_BYTE, nib_mode);
            state    <= DATA;
          end else begin
            cur_byte <= PREAMBLE_BYTE;
            phy_rxd  <= first_symbol(PREAMBLE_BYTE, nib_mode);
            byte_cnt <= byte_cnt + 16'd1;
          end
        end
        DATA: if (tick) begin
          phy_rx_stb <= 1'b1;
          if (!launch) begin
            phy_rxd <= {4'h0, cur_byte[7:4]};
          end else if (und_pend || seen_last) begin
            if (und_pend) underruns <= underruns + CNT_WIDTH'(1);
            else frames_sent <= frames_sent + CNT_WIDTH'(1);
            und_pend  <= 1'b0;
            cur_byte  <= '0;
            phy_rxd   <= '0;
            phy_rx_dv <= 1'b0;
            phy_rx_er <= 1'b0;
            byte_cnt  <= 16'd1;
            if (und_pend && !seen_last) begin
              // The rest of the frame is swallowed silently, so no symbol this slot.
              phy_rx_stb <= 1'b0;
              byte_cnt   <= '0;
              state      <= DROP;
            end else begin
              state <= IFG;
            end
          end else if (s_axis_tvalid) begin
            cur_byte  <= s_axis_tdata;
            phy_rxd   <= first_symbol(s_axis_tdata, nib_mode);
            phy_rx_er <= s_axis_tuser;
            seen_last <= s_axis_tlast;
          end else begin
            cur_byte  <= '0;
            phy_rxd   <= '0;
            phy_rx_er <= 1'b1;
            und_pend  <= 1'b1;
          end
        end
        IFG: if (tick) begin
          if (launch && byte_cnt == 16'(IFG_BYTES)) begin
            state <= IDLE;
          end else begin
            phy_rx_stb <= 1'b1;
            phy_rxd    <= '0;
            if (launch) byte_cnt <= byte_cnt + 16'd1;
          end
        end
        DROP: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            byte_cnt <= '0;
            state    <= IFG;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_phy_rx_emu.sv
// tb/tb_eth_phy_rx_emu.sv - directed scoreboard bench for eth_phy_rx_emu
module tb_eth_phy_rx_emu;

  localparam int IFG_N = 12;

  logic        clk_125;
  logic        reset;
  logic [1:0]  link_speed;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        s_axis_tready;
  logic [7:0]  phy_rxd;
  logic        phy_rx_dv;
  logic        phy_rx_er;
  logic        phy_rx_stb;
  logic [15:0] frames_sent;
  logic [15:0] underruns;

  eth_phy_rx_emu dut (
    .clk_125       (clk_125),
    .reset         (reset),
    .link_speed    (link_speed),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .phy_rxd       (phy_rxd),
    .phy_rx_dv     (phy_rx_dv),
    .phy_rx_er     (phy_rx_er),
    .phy_rx_stb    (phy_rx_stb),
    .frames_sent   (frames_sent),
    .underruns     (underruns)
  );

  initial clk_125 = 1'b0;
  always #4 clk_125 = ~clk_125;

  logic [9:0] sym_q[$];
  logic [9:0] held;
  logic [9:0] exp_sym;
  int n_chk, n_fail, cyc, start_cyc, last_stb, exp_gap, bt, exp_frames, exp_und;
  bit first_pending, first_data, hold_chk, cur_nib;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  // Advance one clock and score whatever the DUT put on the PHY side.
  task automatic step();
    @(negedge clk_125);
    cyc++;
    if (phy_rx_stb === 1'b1) begin
      chk("strobe_expected", 32'(sym_q.size() != 0), 32'd1);
      if (sym_q.size() != 0) begin
        exp_sym = sym_q.pop_front();
        chk("symbol", {22'd0, phy_rxd, phy_rx_dv, phy_rx_er}, {22'd0, exp_sym});
      end
      if (first_pending) begin
        chk("first_strobe_latency", 32'(cyc - start_cyc), 32'd1);
        first_pending = 1'b0;
      end else if (exp_gap != 0) begin
        chk("strobe_gap", 32'(cyc - last_stb), 32'(exp_gap));
      end
      last_stb = cyc;
    end else if (hold_chk) begin
      chk("hold_between_strobes", {22'd0, phy_rxd, phy_rx_dv, phy_rx_er}, {22'd0, held});
    end
    held = {phy_rxd, phy_rx_dv, phy_rx_er};
  endtask

  task automatic push_byte(input logic [7:0] b, input logic dv, input logic er);
    if (cur_nib) begin
      sym_q.push_back({4'h0, b[3:0], dv, er});
      sym_q.push_back({4'h0, b[7:4], dv, er});
    end else begin
      sym_q.push_back({b, dv, er});
    end
  endtask

  task automatic begin_frame(input logic [1:0] spd, input int t_bt);
    link_speed    = spd;
    cur_nib       = spd[0];
    bt            = t_bt;
    exp_gap       = cur_nib ? t_bt / 2 : 1;
    first_pending = 1'b1;
    first_data    = 1'b1;
    start_cyc     = cyc;
    repeat (7) push_byte(8'h55, 1'b1, 1'b0);
    push_byte(8'hD5, 1'b1, 1'b0);
  endtask

  task automatic push_ifg();
    repeat (IFG_N) push_byte(8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic user, input bit push_it);
    logic rdy;
    int   t;
    s_axis_tdata  = b;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
    if (push_it) push_byte(b, 1'b1, user);
    t = 0;
    forever begin
      #1;
      rdy = s_axis_tready;
      if (rdy && first_data) begin
        chk("first_tready_cycle", 32'(cyc - start_cyc), 32'(8 * bt));
        first_data = 1'b0;
      end
      step();
      if (rdy) break;
      t++;
      if (t > 3000) begin
        chk("tready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sym_q.size() != 0 && t < 4000) begin
      step();
      t++;
    end
    chk("scoreboard_drained", 32'(sym_q.size()), 32'd0);
    sym_q.delete();
    repeat (120) step();
    chk("frames_sent", {16'd0, frames_sent}, 32'(exp_frames));
    chk("underruns", {16'd0, underruns}, 32'(exp_und));
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; last_stb = 0; exp_gap = 0; bt = 1;
    exp_frames = 0; exp_und = 0; start_cyc = 0;
    first_pending = 1'b0; first_data = 1'b0; hold_chk = 1'b0; cur_nib = 1'b0;
    held = '0;
    reset = 1'b1; link_speed = 2'b00;
    s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;

    // Reset state
    repeat (3) step();
    chk("reset_rxd", {24'd0, phy_rxd}, 32'd0);
    chk("reset_dv_er_stb_rdy", {28'd0, phy_rx_dv, phy_rx_er, phy_rx_stb, s_axis_tready}, 32'd0);
    chk("reset_frames", {16'd0, frames_sent}, 32'd0);
    chk("reset_underruns", {16'd0, underruns}, 32'd0);
    reset = 1'b0;
    repeat (3) step();
    hold_chk = 1'b1;

    // 1G basic frame
    begin_frame(2'b00, 1);
    send_byte(8'hDE, 1'b0, 1'b0, 1'b1);
    send_byte(8'hAD, 1'b0, 1'b0, 1'b1);
    send_byte(8'hBE, 1'b0, 1'b0, 1'b1);
    send_byte(8'hEF, 1'b1, 1'b0, 1'b1);
    push_ifg();
    exp_frames++;
    drain();

    // 100M single-byte frame, nibble order low then high
    begin_frame(2'b01, 10);
    send_byte(8'hA5, 1'b1, 1'b0, 1'b1);
    push_ifg();
    exp_frames++;
    drain();

    // Underrun after the second of four bytes
    begin_frame(2'b00, 1);
    exp_gap  = 0;
    hold_chk = 1'b0;
    send_byte(8'h01, 1'b0, 1'b0, 1'b1);
    send_byte(8'h02, 1'b0, 1'b0, 1'b1);
    push_byte(8'h00, 1'b1, 1'b1);
    repeat (3) step();
    send_byte(8'h03, 1'b0, 1'b0, 1'b0);
    send_byte(8'h04, 1'b1, 1'b0, 1'b0);
    push_ifg();
    exp_und++;
    drain();
    hold_chk = 1'b1;

    // 10M with error injected on byte 3
    begin_frame(2'b11, 100);
    send_byte(8'h31, 1'b0, 1'b0, 1'b1);
    send_byte(8'h42, 1'b0, 1'b0, 1'b1);
    send_byte(8'h5C, 1'b0, 1'b1, 1'b1);
    send_byte(8'h6D, 1'b1, 1'b0, 1'b1);
    push_ifg();
    exp_frames++;
    drain();

    // Speed change mid-frame is ignored until the next frame
    begin_frame(2'b00, 1);
    send_byte(8'h11, 1'b0, 1'b0, 1'b1);
    send_byte(8'h22, 1'b0, 1'b0, 1'b1);
    link_speed = 2'b01;
    send_byte(8'h33, 1'b0, 1'b0, 1'b1);
    send_byte(8'h44, 1'b1, 1'b0, 1'b1);
    push_ifg();
    exp_frames++;
    drain();
    begin_frame(2'b01, 10);
    send_byte(8'h96, 1'b0, 1'b0, 1'b1);
    send_byte(8'h69, 1'b1, 1'b0, 1'b1);
    push_ifg();
    exp_frames++;
    drain();

    // Reset during DATA, then restart (2'b10 behaves as 1G)
    begin_frame(2'b00, 1);
    send_byte(8'h77, 1'b0, 1'b0, 1'b1);
    send_byte(8'h88, 1'b0, 1'b0, 1'b1);
    hold_chk = 1'b0;
    reset = 1'b1;
    step();
    chk("midreset_rxd", {24'd0, phy_rxd}, 32'd0);
    chk("midreset_dv_er_stb_rdy", {28'd0, phy_rx_dv, phy_rx_er, phy_rx_stb, s_axis_tready}, 32'd0);
    chk("midreset_queue", 32'(sym_q.size()), 32'd0);
    reset = 1'b0;
    sym_q.delete();
    exp_frames = 0;
    exp_und    = 0;
    repeat (3) step();
    chk("postreset_frames", {16'd0, frames_sent}, 32'd0);
    hold_chk = 1'b1;
    begin_frame(2'b10, 1);
    send_byte(8'h99, 1'b1, 1'b0, 1'b1);
    push_ifg();
    exp_frames++;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_phy_rx_emu.md
# eth_phy_rx_emu

Synthesizable, speed-configurable PHY receive emulator. Converts an AXI-Stream byte stream into a GMII/MII-style receive symbol stream with preamble/SFD, inter-frame gap, error injection and underrun handling. Sits in front of the MAC RX path in loopback/hardware-test builds. At 1 Gbps it produces one byte per cycle; at 100/10 Mbps it produces nibble strobes, low nibble first, at the corresponding rates.

## Interface
- `IFG_BYTES`, default 12: inter-frame gap in byte-times.
- `PREAMBLE_EN`, default 1: prepend 7×0x55 + 0xD5 to each frame.
- `CLKS_PER_NIB_100`, default 5: clocks per nibble slot at 100 Mbps.
- `CLKS_PER_NIB_10`, default 50: clocks per nibble slot at 10 Mbps.
- `CNT_WIDTH`, default 16: width of the statistics counters.

Clock and reset are fixed: one clock, `clk_125`; reset is synchronous and active-high, on `reset`.

- `clk_125`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `link_speed`  in  2  speed select: 00 = 1G, 01 = 100M, 11 = 10M, 10 = treated as 1G.
- `s_axis_tdata`  in  8  frame byte.
- `s_axis_tvalid`  in  1  byte valid.
- `s_axis_tlast`  in  1  last byte of frame.
- `s_axis_tuser`  in  1  inject error: assert `phy_rx_er` during this byte's symbols.
- `s_axis_tready`  out  1  byte consumed this cycle.
- `phy_rxd`  out  8  1G: byte. 10/100: nibble in [3:0], with [7:4] = 0.
- `phy_rx_dv`  out  1  data valid, held for the whole frame including preamble.
- `phy_rx_er`  out  1  receive error.
- `phy_rx_stb`  out  1  one-cycle symbol strobe: every cycle at 1G, once per nibble slot otherwise.
- `frames_sent`  out  CNT_WIDTH  count of completed frames; wraps.
- `underruns`  out  CNT_WIDTH  count of aborted frames; wraps.

## Operation
- FSM states: IDLE, PREAMBLE, DATA, IFG, DROP.
- **IDLE**
  - `s_axis_tvalid` = 1 → latch `link_speed` into `speed_q` and go to PREAMBLE.
  - If `PREAMBLE_EN` = 0, go straight to DATA.
  - `speed_q` stays constant until the next return to IDLE; mid-frame speed changes are ignored.
- **PREAMBLE**: 8 byte-times, 0x55 ×7 then 0xD5.
- **DATA**
  - At each byte-slot launch, if `s_axis_tvalid` = 1: `s_axis_tready` = 1 for that single cycle; the byte is loaded into the output register with `er = tuser`.
  - If the accepted byte has `tlast` = 1: after its last symbol, go to IFG and increment `frames_sent`.
  - Underrun (`s_axis_tvalid` = 0 at launch): emit one byte-time of 0x00 with dv = 1 and er = 1, then increment `underruns`.
    - Go to DROP if the current frame's tlast has not yet been seen.
    - Otherwise go to IFG.
- **DROP**: `s_axis_tready` = 1 every cycle; input is discarded up to and including the byte with `tlast`; then go to IFG. No PHY symbols are output.
- **IFG**: `IFG_BYTES` byte-times with dv = 0, er = 0, rxd = 0, strobes still pulsing; then go to IDLE.
- **Nibble modes** (100M/10M): each byte-time is 2 slots, low nibble then high nibble. dv and er are held constant across both slots.
- Outputs stay registered between strobes (dv does not drop between nibbles).

## Timing
- **Reset values**: all outputs 0, state = IDLE, both counters 0, `speed_q` = 00. Reset mid-frame aborts immediately; the next cycle shows dv = 0. No counter increments on abort.
- **Latency**: `s_axis_tvalid` rises in IDLE at cycle N → first strobe with dv = 1 at N+1.
- **Data path**: a byte accepted (`tready` ∧ `tvalid`) at cycle C appears on `phy_rxd` at C+1.
- **1G frame with preamble**, first valid at N:
  - Preamble at N+1..N+8.
  - First `tready` at N+8; first data byte at N+9.
  - A k-byte frame's last data byte is at N+8+k.
  - IFG at N+9+k..N+8+k+IFG_BYTES.
  - Earliest next preamble at N+10+k+IFG_BYTES.
- **Nibble slots**: a slot counter reloads at `CLKS_PER_NIB_x` − 1. Strobe and output update happen on the reload cycle. `tready` asserts only at the launch of the low-nibble slot.
- **Counters**: 1 cycle after the event is detected.
- **Simultaneous events**: `tvalid` and `tlast` both present at the launch of a frame's first byte is legal (1-byte frame).

## Structure
- Shared package `eth_mac_pkg` holds:
  - `link_speed_t` enum (SPEED_1G = 2'b00, SPEED_100M = 2'b01, SPEED_10M = 2'b11);
  - `PREAMBLE_BYTE` = 8'h55 and `SFD_BYTE` = 8'hD5;
  - the `phy_rx_emu_state_t` enum.
- Sub-module `eth_slot_timer`: takes `speed_q` and outputs `stb` plus `nib_phase`, i.e. the divider and nibble-phase toggle.

## Test plan
- **1G basic**: frame DE AD BE EF (tlast on EF), `PREAMBLE_EN` = 1 → 55×7, D5, DE, AD, BE, EF on consecutive cycles with dv = 1; then 12 cycles of dv = 0; `frames_sent` = 1.
- **100M nibble order**: byte 0xA5 → strobes 5 cycles apart with rxd = 5 then A; dv held between strobes; IFG = 24 strobes.
- **Underrun**: drop tvalid after the 2nd of 4 bytes → third data symbol is 00 with er = 1; remaining input bytes consumed with no output; `underruns` = 1, `frames_sent` = 0.
- **Error inject**: `tuser` = 1 on byte 3 at 10M → er = 1 for exactly that byte's 2 strobes (100 cycles total).
- **Reset mid-frame**: assert `reset` during DATA → next cycle all outputs 0; restart in IDLE works.
- **Speed change mid-frame**: switch 00→01 during DATA → current frame finishes at 1G; next frame at 100M.
